// File: rtl/imem_stream_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_stream_loader_if
// Purpose  : Groups the byte-stream handshake and the instruction-memory
//            write port of the program loader into one bundle.
// Signals  : s_valid_i / s_data_i / s_ready_o  - byte stream (loader side)
//            imem_we_o / imem_addr_o / imem_wdata_o - memory write port
// Modports : slave  - the loader (consumes the stream, drives the memory)
//            master - the stream source / memory model (testbench side)
// Revision : 1.0 - initial release
// ============================================================================
interface imem_stream_loader_if #(
    parameter int ADDR_W = 5
) ();
    logic              s_valid_i;
    logic [7:0]        s_data_i;
    logic              s_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        output s_ready_o,
        output imem_we_o,
        output imem_addr_o,
        output imem_wdata_o
    );

    modport master (
        output s_valid_i,
        output s_data_i,
        input  s_ready_o,
        input  imem_we_o,
        input  imem_addr_o,
        input  imem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/imem_stream_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_stream_loader
// Purpose  : Boot-time program loader. Assembles big-endian 32-bit words from
//            a byte stream, writes them to instruction memory, zero-fills the
//            remaining memory (a zero word terminates the program) and then
//            releases the CPU from reset.
// Ports    : clk_i          - system clock
//            rst_i          - asynchronous active-high reset
//            start_i        - single-cycle pulse, starts/restarts a load
//            bus (slave)    - byte stream in, instruction-memory write out
//            cpu_rst_n_o    - active-low CPU reset, high only when running
//            done_o         - image complete, CPU released
//            err_o          - load failed (sticky until start_i / rst_i)
//            word_count_o   - program words written, terminator included
// Options  : LOADER_CHECKSUM_EN - when defined, one checksum byte (mod-256
//            sum of all preceding stream bytes) follows the terminator word
//            and must match before the memory is zero-filled.
// Revision : 1.0 - initial release
// ============================================================================
module imem_stream_loader #(
    parameter int ADDR_W = 5
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              start_i,
    imem_stream_loader_if.slave    bus,
    output logic                   cpu_rst_n_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [ADDR_W:0]        word_count_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_CLEAR = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr = '1;
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_cnt_one   = (ADDR_W+1)'(1);

    state_t            r_state;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;       // first three bytes of the word in flight
    logic [ADDR_W:0]   r_word_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_cpu_rst_n;
    logic              r_done;
    logic              r_err;

    logic [31:0]       w_next_word;
    logic              w_ck_phase;
    logic              w_ck_match;

    assign w_next_word = {r_word, bus.s_data_i};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_sum;        // running mod-256 sum of accepted bytes
    logic              r_ck_phase;   // LOAD is waiting for the checksum byte
    assign w_ck_phase = r_ck_phase;
    assign w_ck_match = (bus.s_data_i == r_sum);
`else
    assign w_ck_phase = 1'b0;
    assign w_ck_match = 1'b0;
`endif

    // Ready is a pure state decode so it never follows s_valid_i.
    assign bus.s_ready_o    = (r_state == S_LOAD);
    assign bus.imem_we_o    = r_we;
    assign bus.imem_addr_o  = r_addr;
    assign bus.imem_wdata_o = r_wdata;
    assign cpu_rst_n_o      = r_cpu_rst_n;
    assign done_o           = r_done;
    assign err_o            = r_err;
    assign word_count_o     = r_word_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= '0;
            r_word      <= '0;
            r_word_cnt  <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_ck_phase  <= 1'b0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            r_we <= 1'b0;

            case (r_state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start_i) begin
                        r_state     <= S_LOAD;
                        r_byte_cnt  <= '0;
                        r_word      <= '0;
                        r_word_cnt  <= '0;
                        r_cpu_rst_n <= 1'b0;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        r_sum       <= '0;
                        r_ck_phase  <= 1'b0;
`endif
                    end
                end

                S_LOAD: begin
                    if (bus.s_valid_i) begin
                        if (w_ck_phase) begin
                            // r_addr still holds the terminator address.
                            if (!w_ck_match) begin
                                r_state <= S_ERROR;
                                r_err   <= 1'b1;
                            end else if (r_addr == c_last_addr) begin
                                r_state     <= S_RUN;
                                r_cpu_rst_n <= 1'b1;
                                r_done      <= 1'b1;
                            end else begin
                                r_state <= S_CLEAR;
                                r_we    <= 1'b1;
                                r_addr  <= r_addr + c_addr_one;
                                r_wdata <= '0;
                            end
                        end else begin
                            r_word     <= w_next_word[23:0];
                            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            r_sum      <= r_sum + bus.s_data_i;
`endif
                            if (r_byte_cnt == 2'd3) begin
                                r_state <= S_WRITE;
                                r_we    <= 1'b1;
                                r_addr  <= r_word_cnt[ADDR_W-1:0];
                                r_wdata <= w_next_word;
                            end
                        end
                    end
                end

                S_WRITE: begin
                    r_word_cnt <= r_word_cnt + c_cnt_one;
                    if (r_wdata == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state    <= S_LOAD;
                        r_ck_phase <= 1'b1;
`else
                        if (r_addr == c_last_addr) begin
                            r_state     <= S_RUN;
                            r_cpu_rst_n <= 1'b1;
                            r_done      <= 1'b1;
                        end else begin
                            r_state <= S_CLEAR;
                            r_we    <= 1'b1;
                            r_addr  <= r_addr + c_addr_one;
                            r_wdata <= '0;
                        end
`endif
                    end else if (r_addr == c_last_addr) begin
                        // Memory full with no room left for a terminator.
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end

                S_CLEAR: begin
                    if (r_addr == c_last_addr) begin
                        r_state     <= S_RUN;
                        r_cpu_rst_n <= 1'b1;
                        r_done      <= 1'b1;
                    end else begin
                        r_we   <= 1'b1;
                        r_addr <= r_addr + c_addr_one;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_stream_loader
// Purpose  : Self-checking bench for imem_stream_loader. Program images are
//            checked against an image/status model derived from the loader's
//            rules (words up to the terminator, zeros after it).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_stream_loader;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cpu_rst_n;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   wc;

    imem_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_stream_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .bus          (bus),
        .cpu_rst_n_o  (cpu_rst_n),
        .done_o       (done),
        .err_o        (err),
        .word_count_o (wc)
    );

    always #5 clk = ~clk;

    // Memory model fed by the DUT write port.
    logic [31:0] mem_dut [DEPTH];
    int          wr_cnt = 0;
    int          ready_viol = 0;
    int          wr_addr_q [$];

    always @(posedge clk) begin
        if (bus.imem_we_o === 1'b1) begin
            mem_dut[bus.imem_addr_o] = bus.imem_wdata_o;
            wr_cnt++;
            wr_addr_q.push_back(int'(bus.imem_addr_o));
            if (bus.s_ready_o !== 1'b0) ready_viol++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; leaves at posedge+1 after the start edge.
    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_cpu_rst_n", cpu_rst_n, 0);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        bus.s_valid_i = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = b;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.s_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 8'($urandom);
        chk("byte_accept", ok, 1);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[15:8] = 8'h00;
        if (w == 32'd0) w = 32'h1;
        return w;
    endfunction

    // Full load through the reference model: the image is every word up to
    // and including the first zero word, zero-filled afterwards; with no zero
    // word in the first DEPTH words the load fails after DEPTH writes.
    task automatic run_load(input logic [31:0] words[$], input int maxgap,
                            input bit bad_ck, input string tag);
        logic [31:0] exp_img [DEPTH];
        logic [7:0]  bq [$];
        logic [7:0]  sum;
        logic [7:0]  bt;
        int          t;
        int          nsend;
        int          exp_wr;
        int          bad;
        bit          exp_err;

        t = -1;
        for (int i = 0; i < words.size() && i < DEPTH; i++) begin
            if (words[i] == 32'd0) begin
                t = i;
                break;
            end
        end
        nsend = (t >= 0) ? t + 1 : DEPTH;
        sum = 8'd0;
        for (int i = 0; i < nsend; i++) begin
            for (int k = 3; k >= 0; k--) begin
                bt = words[i][8*k +: 8];
                bq.push_back(bt);
                sum = sum + bt;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (t >= 0) bq.push_back(bad_ck ? sum + 8'd1 : sum);
`endif
        exp_err = (t < 0) || bad_ck;
        exp_wr  = exp_err ? nsend : DEPTH;
        for (int a = 0; a < DEPTH; a++) begin
            if (a < nsend)    exp_img[a] = words[a];
            else if (exp_err) exp_img[a] = 'x;
            else              exp_img[a] = 32'd0;
        end

        for (int a = 0; a < DEPTH; a++) mem_dut[a] = 'x;
        wr_cnt = 0;
        ready_viol = 0;
        wr_addr_q.delete();

        start_pulse();
        foreach (bq[i]) send_byte(bq[i], $urandom_range(0, maxgap));
        for (int c = 0; c < 200 && !(done === 1'b1 || err === 1'b1); c++) @(negedge clk);

        chk($sformatf("%s_done", tag), done, !exp_err);
        chk($sformatf("%s_err", tag), err, exp_err);
        chk($sformatf("%s_cpu_rst_n", tag), cpu_rst_n, !exp_err);
        chk($sformatf("%s_word_count", tag), wc, nsend);
        chk($sformatf("%s_write_count", tag), wr_cnt, exp_wr);
        chk($sformatf("%s_ready_during_write", tag), ready_viol, 0);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem_dut[a] !== exp_img[a]) bad++;
        chk($sformatf("%s_image_mismatches", tag), bad, 0);
        bad = 0;
        foreach (wr_addr_q[i]) if (wr_addr_q[i] != i) bad++;
        chk($sformatf("%s_write_order", tag), bad, 0);
    endtask

    initial begin
        logic [31:0] q [$];
        int          w0;

        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 8'h00;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.s_ready_o, 0);
        chk("rst_we", bus.imem_we_o, 0);
        chk("rst_addr", bus.imem_addr_o, 0);
        chk("rst_wdata", bus.imem_wdata_o, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_word_count", wc, 0);
        rst = 1'b0;

        // IDLE ignores the stream
        bus.s_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready", bus.s_ready_o, 0);
        chk("idle_writes", wr_cnt, 0);
        bus.s_valid_i = 1'b0;

        // Basic load
        q = '{32'hDC410005, 32'h00000000};
        run_load(q, 0, 1'b0, "basic");

        // Randomised images with stalls; each start also reloads from RUN
        for (int it = 0; it < 4; it++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) q.push_back(rnd_word());
            q.push_back(32'd0);
            q.push_back(rnd_word());   // beyond the terminator, never sent
            run_load(q, 7, 1'b0, $sformatf("stall%0d", it));
        end

        // Terminator at the last address: no zero-fill writes
        q.delete();
        for (int i = 0; i < DEPTH - 1; i++) q.push_back(rnd_word());
        q.push_back(32'd0);
        run_load(q, 2, 1'b0, "term_last");

        // Overflow: DEPTH nonzero words
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(rnd_word());
        run_load(q, 2, 1'b0, "overflow");
        chk("overflow_last_addr", wr_addr_q[wr_addr_q.size()-1], DEPTH - 1);

        // Recovery after error (start pulse clears err_o)
        q = '{32'h12345678, 32'h00A000B0, 32'h0};
        run_load(q, 3, 1'b0, "after_err");

        // Asynchronous reset after two bytes of word 3
        start_pulse();
        for (int i = 0; i < 3; i++)
            for (int k = 3; k >= 0; k--) send_byte(8'(i + k + 1), $urandom_range(0, 3));
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 0);
        w0 = wr_cnt;
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", bus.s_ready_o, 0);
        chk("arst_we", bus.imem_we_o, 0);
        chk("arst_addr", bus.imem_addr_o, 0);
        chk("arst_wdata", bus.imem_wdata_o, 0);
        chk("arst_cpu_rst_n", cpu_rst_n, 0);
        chk("arst_word_count", wc, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("arst_no_write", wr_cnt, w0);
        q = '{32'hCAFEF00D, 32'h00000001, 32'h0};
        run_load(q, 4, 1'b0, "after_arst");

`ifdef LOADER_CHECKSUM_EN
        q = '{32'h01020304, 32'h00000000};
        run_load(q, 1, 1'b0, "ck_good");
        run_load(q, 1, 1'b1, "ck_bad");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
